// File: rtl/lcd_refresh_ctrl_pkg.sv
// Shared LCD definitions: generator pointer landmarks, controller states and
// default timing.
package lcd_refresh_ctrl_pkg;

   // Generator command pointer: first character slot and the parked value
   // reached after the last character has been written.
   localparam logic [5:0] LCD_PTR_FIRST_CHAR = 6'd4;
   localparam logic [5:0] LCD_PTR_DONE       = 6'd44;

   localparam int LCD_NCHAR_DEF   = 40;
   localparam int LCD_RST_DEF     = 4;
   localparam int LCD_HOLD_DEF    = 2600;
   localparam int LCD_TIMEOUT_DEF = 200000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RST  = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } lcd_state_e;

endpackage

// File: rtl/lcd_refresh_ctrl_nibble_feed.sv
// Two-stage nibble feed: the pointer is registered once, then decoded into the
// character nibble, so data_in meets the generator's twice-delayed pointer.
module lcd_nibble_feed
   import lcd_refresh_ctrl_pkg::*;
#(
   parameter int NCHAR = LCD_NCHAR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         ptr,
   input  logic [4*NCHAR-1:0] snap,
   output logic [3:0]         nib
);

   logic [5:0] ptr_d1_q, ptr_d1_d;
   logic [3:0] nib_q, nib_d;

   // Slot k maps to the k-th nibble counted from the MSB end of snap;
   // pointers outside the character window feed zero.
   always_comb begin
      ptr_d1_d = ptr;
      nib_d    = 4'h0;
      for (int k = 0; k < NCHAR; k++) begin
         if (ptr_d1_q == LCD_PTR_FIRST_CHAR + 6'(k)) begin
            nib_d = snap[4*(NCHAR-1-k) +: 4];
         end
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_d1_q <= '0;
         nib_q    <= '0;
      end else begin
         ptr_d1_q <= ptr_d1_d;
         nib_q    <= nib_d;
      end
   end

   assign nib = nib_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// LCD refresh controller: accepts a screen of hex digits, restarts the LCD
// instruction generator and tracks its pointer until the screen is written.
//
// state | meaning
// IDLE  | ready for a screen word; in_ready high
// RST   | restart pulse to the generator for RST_CYCLES cycles
// RUN   | generator writing; wait for an armed pointer of 44, or time out
// HOLD  | dwell HOLD_CYCLES after the last write, then pulse done
module lcd_refresh_ctrl
   import lcd_refresh_ctrl_pkg::*;
#(
   parameter int NCHAR          = LCD_NCHAR_DEF,
   parameter int RST_CYCLES     = LCD_RST_DEF,
   parameter int HOLD_CYCLES    = LCD_HOLD_DEF,
   parameter int TIMEOUT_CYCLES = LCD_TIMEOUT_DEF
) (
   input  logic               oneUSClk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [4*NCHAR-1:0] in_data,
   output logic               in_ready,
   input  logic [5:0]         lcd_cmd_ptr,
   output logic               lcd_rst,
   output logic [3:0]         data_in,
   output logic               busy,
   output logic               done,
   output logic               err
);

   lcd_state_e         state_q, state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               armed_q, armed_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic [4*NCHAR-1:0] snap_q, snap_d;

   // Next-state logic; the single down-counter is reloaded on every state
   // entry and holds at zero otherwise, so it never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
      armed_d = armed_q;
      err_d   = err_q;
      done_d  = 1'b0;
      snap_d  = snap_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               snap_d  = in_data;
               err_d   = 1'b0;
               armed_d = 1'b0;
               cnt_d   = 32'(RST_CYCLES - 1);
               state_d = RST;
            end
         end
         RST: begin
            if (cnt_q == 32'd0) begin
               cnt_d   = 32'(TIMEOUT_CYCLES - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            // A pointer left at 44 by the previous screen must not complete
            // this one: only a 44 seen after a lower value counts.
            if (lcd_cmd_ptr < LCD_PTR_DONE) begin
               armed_d = 1'b1;
            end
            if (armed_q && (lcd_cmd_ptr == LCD_PTR_DONE)) begin
               cnt_d   = 32'(HOLD_CYCLES - 1);
               state_d = HOLD;
            end else if (cnt_q == 32'd0) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (cnt_q == 32'd0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and control registers.
   always_ff @(posedge oneUSClk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         err_q   <= err_d;
         done_q  <= done_d;
         snap_q  <= snap_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign lcd_rst  = (state_q == RST);
   assign done     = done_q;
   assign err      = err_q;

   lcd_nibble_feed #(.NCHAR(NCHAR)) u_feed (
      .clk  (oneUSClk),
      .rst  (reset),
      .ptr  (lcd_cmd_ptr),
      .snap (snap_q),
      .nib  (data_in)
   );

endmodule
